// File: rtl/scarv_cop_palu_arbiter_if.sv
// Requester/datapath bundle for the PALU arbiter. The arbiter takes the slave
// side. The master side belongs to the requesters, datapath and debug observers.
interface scarv_cop_palu_arbiter_if;
  logic        r0_req;
  logic        r0_lock;
  logic [2:0]  r0_pw;
  logic [63:0] r0_add_a;
  logic [63:0] r0_add_b;
  logic [4:0]  r0_shf_sham;
  logic [31:0] r0_shf_a;
  logic        r0_gnt;

  logic        r1_req;
  logic        r1_lock;
  logic [2:0]  r1_pw;
  logic [63:0] r1_add_a;
  logic [63:0] r1_add_b;
  logic [4:0]  r1_shf_sham;
  logic [31:0] r1_shf_a;
  logic        r1_gnt;

  logic [63:0] add_a;
  logic [63:0] add_b;
  logic [2:0]  add_pw;
  logic [4:0]  shf_sham;
  logic [31:0] shf_a;
  logic        busy;
  logic        err;

  // Observability of the owner FSM, priority bit and lock counter.
  logic [1:0]  dbg_state;
  logic        dbg_prio;
  logic [5:0]  dbg_lock_ctr;
  logic        dbg_lock_expired;

  modport master (
    output r0_req, r0_lock, r0_pw, r0_add_a, r0_add_b, r0_shf_sham, r0_shf_a,
    output r1_req, r1_lock, r1_pw, r1_add_a, r1_add_b, r1_shf_sham, r1_shf_a,
    input  r0_gnt, r1_gnt, add_a, add_b, add_pw, shf_sham, shf_a, busy, err,
    input  dbg_state, dbg_prio, dbg_lock_ctr, dbg_lock_expired
  );

  modport slave (
    input  r0_req, r0_lock, r0_pw, r0_add_a, r0_add_b, r0_shf_sham, r0_shf_a,
    input  r1_req, r1_lock, r1_pw, r1_add_a, r1_add_b, r1_shf_sham, r1_shf_a,
    output r0_gnt, r1_gnt, add_a, add_b, add_pw, shf_sham, shf_a, busy, err,
    output dbg_state, dbg_prio, dbg_lock_ctr, dbg_lock_expired
  );
endinterface

// File: rtl/scarv_cop_palu_arbiter.sv
// Two-requester arbiter for the shared PALU adder/shifter with lockable grants.
// Define SCARV_COP_PALU_ARB_WDOG_EN to enable the lock watchdog and sticky err.
module scarv_cop_palu_arbiter #(
  parameter int unsigned LOCK_MAX = 32
) (
  input logic                     g_clk,
  input logic                     g_resetn,
  scarv_cop_palu_arbiter_if.slave bus
);
  // Handshake: rN_req is a same-cycle request. rN_gnt=1 means rN's operands
  // drive the datapath this cycle. At most one grant is high in any cycle.

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;
  localparam logic [5:0] LOCK_MAX_C = LOCK_MAX[5:0];

  logic [1:0] state_q, state_d;
  logic       prio_q, prio_d;
  logic [5:0] lock_ctr_q, lock_ctr_d;
  logic [1:0] eff_state;
  logic       eff_prio;
  logic       gnt0, gnt1;
  logic       own_req;
  logic       lock_expired;

  // While reset is asserted, the outputs behave as if idle with R0 favoured.
  assign eff_state    = g_resetn ? state_q : ST_IDLE;
  assign eff_prio     = g_resetn & prio_q;
  assign lock_expired = (lock_ctr_q >= LOCK_MAX_C);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (eff_state)
      ST_LOCK0: gnt0 = bus.r0_req;
      ST_LOCK1: gnt1 = bus.r1_req;
      default: begin
        if (bus.r0_req && bus.r1_req) begin
          gnt0 = ~eff_prio;
          gnt1 = eff_prio;
        end else begin
          gnt0 = bus.r0_req;
          gnt1 = bus.r1_req;
        end
      end
    endcase
  end

  always_comb begin
    bus.add_a    = 64'd0;
    bus.add_b    = 64'd0;
    bus.add_pw   = 3'd0;
    bus.shf_sham = 5'd0;
    bus.shf_a    = 32'd0;
    if (gnt0) begin
      bus.add_a    = bus.r0_add_a;
      bus.add_b    = bus.r0_add_b;
      bus.add_pw   = bus.r0_pw;
      bus.shf_sham = bus.r0_shf_sham;
      bus.shf_a    = bus.r0_shf_a;
    end else if (gnt1) begin
      bus.add_a    = bus.r1_add_a;
      bus.add_b    = bus.r1_add_b;
      bus.add_pw   = bus.r1_pw;
      bus.shf_sham = bus.r1_shf_sham;
      bus.shf_a    = bus.r1_shf_a;
    end
  end

  assign own_req = (state_q == ST_LOCK1) ? bus.r1_req : bus.r0_req;

`ifdef SCARV_COP_PALU_ARB_WDOG_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    lock_ctr_d = lock_ctr_q;
`ifdef SCARV_COP_PALU_ARB_WDOG_EN
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt0) begin
          prio_d = 1'b1;
          if (bus.r0_lock) begin
            state_d    = ST_LOCK0;
            lock_ctr_d = 6'd1;
          end
        end else if (gnt1) begin
          prio_d = 1'b0;
          if (bus.r1_lock) begin
            state_d    = ST_LOCK1;
            lock_ctr_d = 6'd1;
          end
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        // Losing the lock always hands priority to the other requester.
        if (own_req) begin
          lock_ctr_d = (lock_ctr_q == 6'd63) ? 6'd63 : lock_ctr_q + 6'd1;
`ifdef SCARV_COP_PALU_ARB_WDOG_EN
          if (lock_expired) begin
            state_d    = ST_IDLE;
            prio_d     = (state_q == ST_LOCK0);
            lock_ctr_d = 6'd0;
            err_d      = 1'b1;
          end
`endif
        end else begin
          state_d    = ST_IDLE;
          prio_d     = (state_q == ST_LOCK0);
          lock_ctr_d = 6'd0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        lock_ctr_d = 6'd0;
      end
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      lock_ctr_q <= 6'd0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      lock_ctr_q <= lock_ctr_d;
    end
  end

`ifdef SCARV_COP_PALU_ARB_WDOG_EN
  always_ff @(posedge g_clk) begin
    if (!g_resetn) err_q <= 1'b0;
    else           err_q <= err_d;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.r0_gnt           = gnt0;
  assign bus.r1_gnt           = gnt1;
  assign bus.busy             = (state_q != ST_IDLE);
  assign bus.dbg_state        = state_q;
  assign bus.dbg_prio         = prio_q;
  assign bus.dbg_lock_ctr     = lock_ctr_q;
  assign bus.dbg_lock_expired = lock_expired;
endmodule

// File: tb/tb_scarv_cop_palu_arbiter.sv
// Randomized bench for scarv_cop_palu_arbiter against a behavioural ownership model.
// With SCARV_COP_PALU_ARB_WDOG_EN the DUT is built with LOCK_MAX=4.
module tb_scarv_cop_palu_arbiter;
`ifdef SCARV_COP_PALU_ARB_WDOG_EN
  localparam int TB_LOCK_MAX = 4;
  localparam bit WDOG = 1'b1;
`else
  localparam int TB_LOCK_MAX = 32;
  localparam bit WDOG = 1'b0;
`endif

  logic g_clk;
  logic g_resetn;
  scarv_cop_palu_arbiter_if bus ();

  scarv_cop_palu_arbiter #(.LOCK_MAX(TB_LOCK_MAX)) dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (bus)
  );

  // clock / reset
  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // stimulus state, indexed by requester
  logic        req [2];
  logic        lk  [2];
  logic [2:0]  pw  [2];
  logic [63:0] aa  [2];
  logic [63:0] ab  [2];
  logic [4:0]  sh  [2];
  logic [31:0] sa  [2];

  // reference model: who holds a lock (-1 none), who wins a tie, lock age
  int m_locker;
  int m_prio;
  int m_age;
  bit m_err;

  int n_vec;
  int n_miss;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    bus.r0_req = req[0]; bus.r0_lock = lk[0]; bus.r0_pw = pw[0];
    bus.r0_add_a = aa[0]; bus.r0_add_b = ab[0];
    bus.r0_shf_sham = sh[0]; bus.r0_shf_a = sa[0];
    bus.r1_req = req[1]; bus.r1_lock = lk[1]; bus.r1_pw = pw[1];
    bus.r1_add_a = aa[1]; bus.r1_add_b = ab[1];
    bus.r1_shf_sham = sh[1]; bus.r1_shf_a = sa[1];
  endtask

  task automatic rand_fields();
    for (int i = 0; i < 2; i++) begin
      pw[i] = 3'($urandom_range(0, 7));
      aa[i] = {$urandom, $urandom};
      ab[i] = {$urandom, $urandom};
      sh[i] = 5'($urandom_range(0, 31));
      sa[i] = $urandom;
    end
  endtask

  function automatic int winner();
    int lockr;
    int pr;
    lockr = g_resetn ? m_locker : -1;
    pr    = g_resetn ? m_prio : 0;
    if (lockr >= 0) return req[lockr] ? lockr : -1;
    if (req[0] && req[1]) return pr;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic model_step(input int w);
    if (!g_resetn) begin
      m_locker = -1; m_prio = 0; m_age = 0; m_err = 1'b0;
    end else if (m_locker >= 0) begin
      if (!req[m_locker]) begin
        m_prio = 1 - m_locker; m_locker = -1; m_age = 0;
      end else if (WDOG && m_age >= TB_LOCK_MAX) begin
        m_prio = 1 - m_locker; m_locker = -1; m_age = 0; m_err = 1'b1;
      end else begin
        m_age = (m_age >= 63) ? 63 : m_age + 1;
      end
    end else if (w >= 0) begin
      m_prio = 1 - w;
      if (lk[w]) begin
        m_locker = w; m_age = 1;
      end
    end
  endtask

  task automatic run_cycle();
    int w;
    logic [1:0] eg;
    drive();
    @(negedge g_clk);
    w = winner();
    exp_q.push_back({w == 1, w == 0});
    eg = exp_q.pop_front();
    check("r0_gnt", 64'(bus.r0_gnt), 64'(eg[0]));
    check("r1_gnt", 64'(bus.r1_gnt), 64'(eg[1]));
    check("add_a", bus.add_a, (w >= 0) ? aa[w] : 64'd0);
    check("add_b", bus.add_b, (w >= 0) ? ab[w] : 64'd0);
    check("add_pw", 64'(bus.add_pw), (w >= 0) ? 64'(pw[w]) : 64'd0);
    check("shf_sham", 64'(bus.shf_sham), (w >= 0) ? 64'(sh[w]) : 64'd0);
    check("shf_a", 64'(bus.shf_a), (w >= 0) ? 64'(sa[w]) : 64'd0);
    if (g_resetn) begin
      check("busy", 64'(bus.busy), 64'(m_locker >= 0));
      check("err", 64'(bus.err), 64'(m_err));
    end
    model_step(w);
    @(posedge g_clk);
    #1;
  endtask

  task automatic set_req(input logic q0, input logic l0, input logic q1, input logic l1);
    req[0] = q0; lk[0] = l0; req[1] = q1; lk[1] = l1;
  endtask

  task automatic do_reset();
    g_resetn = 1'b0;
    rand_fields();
    run_cycle();
    run_cycle();
    g_resetn = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    m_locker = -1; m_prio = 0; m_age = 0; m_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; lk[i] = 1'b0; pw[i] = '0; aa[i] = '0; ab[i] = '0; sh[i] = '0; sa[i] = '0;
    end
    g_resetn = 1'b0;
    drive();
    @(posedge g_clk);
    #1;
    do_reset();

    // lone R1 request with a small adder operand
    set_req(1'b0, 1'b0, 1'b1, 1'b0);
    rand_fields();
    aa[1] = 64'h5;
    run_cycle();

    // no requests: everything idle and zero
    set_req(1'b0, 1'b0, 1'b0, 1'b0);
    rand_fields();
    run_cycle();

    // contention from reset alternates R0, R1, R0, ...
    do_reset();
    set_req(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rand_fields();
      run_cycle();
    end

    // long R0 lock with R1 waiting, then release
    do_reset();
    set_req(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      rand_fields();
      run_cycle();
    end
    req[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      run_cycle();
    end

    // reset while R1 holds a lock
    do_reset();
    set_req(1'b0, 1'b0, 1'b1, 1'b1);
    rand_fields();
    run_cycle();
    lk[1] = 1'b0;
    rand_fields();
    run_cycle();
    set_req(1'b1, 1'b0, 1'b1, 1'b0);
    g_resetn = 1'b0;
    rand_fields();
    run_cycle();
    g_resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      run_cycle();
    end

    // random traffic; a lock holder tends to keep requesting
    for (int n = 0; n < 3000; n++) begin
      g_resetn = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < 2; i++) begin
        if (m_locker == i) req[i] = ($urandom_range(0, 15) != 0);
        else               req[i] = ($urandom_range(0, 2) != 0);
        lk[i] = ($urandom_range(0, 5) == 0);
      end
      rand_fields();
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
